// File: rtl/ras_pkg.sv
// Shared types and defaults for the return-address stack controller.
package ras_pkg;

    localparam int unsigned RAS_DEPTH_DEFAULT = 8;
    localparam int unsigned RAS_AW_DEFAULT    = 32;

    typedef enum logic [1:0] {
        RAS_NONE,
        RAS_PUSH,
        RAS_POP,
        RAS_REPL
    } ras_op_e;

    // Push+pop on an empty stack has nothing to replace, so it degrades to a plain push.
    function automatic ras_op_e ras_decode(input logic push, input logic pop, input logic empty);
        ras_op_e op;
        op = RAS_NONE;
        if (push && pop) begin
            op = empty ? RAS_PUSH : RAS_REPL;
        end else if (push) begin
            op = RAS_PUSH;
        end else if (pop) begin
            op = RAS_POP;
        end
        return op;
    endfunction

endpackage

// File: rtl/ras_perf_cnt.sv
// Push and underflow event counters for the return-address stack; cleared only by rst.
module ras_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_evt_i,
    input  logic        underflow_evt_i,
    output logic [31:0] push_cnt_o,
    output logic [31:0] underflow_cnt_o
);

    logic [31:0] push_cnt_q, push_cnt_d;
    logic [31:0] underflow_cnt_q, underflow_cnt_d;

    always_comb begin
        push_cnt_d      = push_cnt_q + (push_evt_i ? 32'd1 : 32'd0);
        underflow_cnt_d = underflow_cnt_q + (underflow_evt_i ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            push_cnt_q      <= '0;
            underflow_cnt_q <= '0;
        end else begin
            push_cnt_q      <= push_cnt_d;
            underflow_cnt_q <= underflow_cnt_d;
        end
    end

    assign push_cnt_o      = push_cnt_q;
    assign underflow_cnt_o = underflow_cnt_q;

endmodule

// File: rtl/ras_ctrl.sv
// Circular return-address stack for decode-stage return prediction.
// Optional performance counters are built when RAS_PERF_EN is defined.
module ras_ctrl
    import ras_pkg::*;
#(
    parameter int unsigned DEPTH = RAS_DEPTH_DEFAULT,
    parameter int unsigned AW    = RAS_AW_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [AW-1:0]            push_addr_i,
    input  logic                     pop_i,
    output logic                     top_valid_o,
    output logic [AW-1:0]            top_addr_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    output logic [31:0]              push_cnt_o,
    output logic [31:0]              underflow_cnt_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [AW-1:0] mem_q [DEPTH];
    logic [PW-1:0] tos_q, tos_d, tos_inc, wr_ptr;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          wr_en;
    logic          empty, full;
    ras_op_e       op;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign tos_inc = tos_q + PW'(1);
    assign op      = ras_decode(push_i, pop_i, empty);

    always_comb begin
        tos_d      = tos_q;
        count_d    = count_q;
        overflow_d = 1'b0;
        wr_en      = 1'b0;
        wr_ptr     = tos_inc;
        if (flush_i) begin
            tos_d   = '0;
            count_d = '0;
        end else if (!stall_i) begin
            case (op)
                RAS_REPL: begin
                    wr_en  = 1'b1;
                    wr_ptr = tos_q;
                end
                RAS_PUSH: begin
                    // When full, the slot above tos holds the oldest entry and is overwritten.
                    tos_d = tos_inc;
                    wr_en = 1'b1;
                    if (full) begin
                        overflow_d = 1'b1;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
                RAS_POP: begin
                    if (!empty) begin
                        tos_d   = tos_q - PW'(1);
                        count_d = count_q - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tos_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            tos_q      <= tos_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            if (wr_en) begin
                mem_q[wr_ptr] <= push_addr_i;
            end
        end
    end

    assign top_addr_o  = mem_q[tos_q];
    assign top_valid_o = !empty;
    assign count_o     = count_q;
    assign overflow_o  = overflow_q;

`ifdef RAS_PERF_EN
    logic push_evt, underflow_evt;

    assign push_evt      = !flush_i && !stall_i && push_i;
    assign underflow_evt = !flush_i && !stall_i && (op == RAS_POP) && empty;

    ras_perf_cnt u_perf_cnt (
        .clk             (clk),
        .rst             (rst),
        .push_evt_i      (push_evt),
        .underflow_evt_i (underflow_evt),
        .push_cnt_o      (push_cnt_o),
        .underflow_cnt_o (underflow_cnt_o)
    );
`else
    assign push_cnt_o      = '0;
    assign underflow_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ras_ctrl.sv
// Directed self-checking bench for ras_ctrl (DEPTH=8, AW=32).
module tb_ras_ctrl;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 32;
`ifdef RAS_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   stall_i;
    logic                   flush_i;
    logic                   push_i;
    logic [AW-1:0]          push_addr_i;
    logic                   pop_i;
    logic                   top_valid_o;
    logic [AW-1:0]          top_addr_o;
    logic [$clog2(DEPTH):0] count_o;
    logic                   overflow_o;
    logic [31:0]            push_cnt_o;
    logic [31:0]            underflow_cnt_o;

    int checks   = 0;
    int failures = 0;
    int exp_push = 0;

    always #5 clk = ~clk;

    ras_ctrl #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .push_i          (push_i),
        .push_addr_i     (push_addr_i),
        .pop_i           (pop_i),
        .top_valid_o     (top_valid_o),
        .top_addr_o      (top_addr_o),
        .count_o         (count_o),
        .overflow_o      (overflow_o),
        .push_cnt_o      (push_cnt_o),
        .underflow_cnt_o (underflow_cnt_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic push, input logic pop, input logic [AW-1:0] addr);
        push_i      = push;
        pop_i       = pop;
        push_addr_i = addr;
        step();
        push_i = 1'b0;
        pop_i  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
        push_i = 1'b0; pop_i = 1'b0; push_addr_i = '0;
        step(); step();
        rst = 1'b0;
        check("rst_valid", 32'(top_valid_o), 32'd0);
        check("rst_addr", top_addr_o, 32'd0);
        check("rst_count", 32'(count_o), 32'd0);
        check("rst_ovf", 32'(overflow_o), 32'd0);
        check("rst_pushcnt", push_cnt_o, 32'd0);
        check("rst_undcnt", underflow_cnt_o, 32'd0);

        // Two pushes then a pop
        drive(1'b1, 1'b0, 32'h0040_0008);
        drive(1'b1, 1'b0, 32'h0040_0010);
        exp_push += 2;
        check("push2_top", top_addr_o, 32'h0040_0010);
        check("push2_count", 32'(count_o), 32'd2);
        drive(1'b0, 1'b1, '0);
        check("pop1_top", top_addr_o, 32'h0040_0008);
        check("pop1_count", 32'(count_o), 32'd1);
        drive(1'b0, 1'b1, '0);
        check("pop2_count", 32'(count_o), 32'd0);

        // Underflow
        drive(1'b0, 1'b1, '0);
        check("und_count", 32'(count_o), 32'd0);
        check("und_valid", 32'(top_valid_o), 32'd0);
        check("und_cnt", underflow_cnt_o, PERF ? 32'd1 : 32'd0);

        // Overflow: nine pushes into eight slots
        for (int k = 0; k < 9; k++) begin
            drive(1'b1, 1'b0, 32'h100 + 32'(4 * k));
            check($sformatf("ovf_pulse%0d", k), 32'(overflow_o), (k == 8) ? 32'd1 : 32'd0);
        end
        exp_push += 9;
        check("ovf_count", 32'(count_o), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ovf_pop_top%0d", i), top_addr_o, 32'h120 - 32'(4 * i));
            drive(1'b0, 1'b1, '0);
            check($sformatf("ovf_pop_ovf%0d", i), 32'(overflow_o), 32'd0);
        end
        check("ovf_empty_valid", 32'(top_valid_o), 32'd0);
        check("ovf_empty_count", 32'(count_o), 32'd0);

        // Push+pop replaces top without moving the pointer
        drive(1'b1, 1'b0, 32'h1f0);
        drive(1'b1, 1'b0, 32'h1f8);
        drive(1'b1, 1'b0, 32'h200);
        drive(1'b1, 1'b1, 32'h300);
        exp_push += 4;
        check("repl_top", top_addr_o, 32'h300);
        check("repl_count", 32'(count_o), 32'd3);
        drive(1'b0, 1'b1, '0);
        check("repl_pop_top", top_addr_o, 32'h1f8);
        check("repl_pop_count", 32'(count_o), 32'd2);

        // Stall freezes; flush wins over stall and push
        stall_i = 1'b1;
        drive(1'b1, 1'b0, 32'h500);
        check("stall_top", top_addr_o, 32'h1f8);
        check("stall_count", 32'(count_o), 32'd2);
        flush_i = 1'b1;
        drive(1'b1, 1'b0, 32'h600);
        stall_i = 1'b0; flush_i = 1'b0;
        check("sflush_count", 32'(count_o), 32'd0);
        check("sflush_valid", 32'(top_valid_o), 32'd0);
        check("sflush_pushcnt", push_cnt_o, PERF ? 32'(exp_push) : 32'd0);

        drive(1'b1, 1'b0, 32'h700);
        exp_push += 1;
        check("postflush_top", top_addr_o, 32'h700);
        check("postflush_count", 32'(count_o), 32'd1);

        flush_i = 1'b1;
        drive(1'b1, 1'b0, 32'h800);
        flush_i = 1'b0;
        check("flushpush_count", 32'(count_o), 32'd0);

        // Push+pop on empty acts as a push
        drive(1'b1, 1'b1, 32'h900);
        exp_push += 1;
        check("emptyrepl_top", top_addr_o, 32'h900);
        check("emptyrepl_count", 32'(count_o), 32'd1);
        check("pushcnt", push_cnt_o, PERF ? 32'(exp_push) : 32'd0);
        check("undcnt_hold", underflow_cnt_o, PERF ? 32'd1 : 32'd0);

        // Reset mid-sequence overrides a concurrent push
        drive(1'b1, 1'b0, 32'ha00);
        rst = 1'b1;
        drive(1'b1, 1'b0, 32'hb00);
        rst = 1'b0;
        check("mrst_valid", 32'(top_valid_o), 32'd0);
        check("mrst_addr", top_addr_o, 32'd0);
        check("mrst_count", 32'(count_o), 32'd0);
        check("mrst_ovf", 32'(overflow_o), 32'd0);
        check("mrst_pushcnt", push_cnt_o, 32'd0);
        check("mrst_undcnt", underflow_cnt_o, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
